neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer_pkg.sv | 23 ++
 rtl/neuron_sequencer_if.sv | 36 +++
 rtl/multiplicant.sv | 20 ++
 rtl/neuron_sequencer.sv | 109 ++++++++++
 tb/tb_neuron_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/neuron_sequencer_pkg.sv
// Shared state encodings, default sizing and width helpers for the neuron sequencer.
package neuron_sequencer_pkg;

   localparam int DEF_N_INPUTS    = 4;
   localparam int DEF_INPUT_BITS  = 3;
   localparam int DEF_WEIGHT_BITS = 3;
   localparam int DEF_N_NEURONS   = 8;
   localparam int DEF_THRESHOLD   = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      MUL   = 3'd2,
      ACC   = 3'd3,
      OUT   = 3'd4
   } state_t;

   // Dot-product width: one lane product plus carry growth across the lanes.
   function automatic int sum_bits(int ib, int wb, int n);
      return ib + wb + $clog2(n);
   endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Handshake bundle between the sequencer, its vector source, weight ROM and result consumer.
interface neuron_sequencer_if
   import neuron_sequencer_pkg::*;
#(
   parameter int N_INPUTS    = DEF_N_INPUTS,
   parameter int INPUT_BITS  = DEF_INPUT_BITS,
   parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
   parameter int N_NEURONS   = DEF_N_NEURONS
) ();
   localparam int SUM_BITS = sum_bits(INPUT_BITS, WEIGHT_BITS, N_INPUTS);
   localparam int AW       = $clog2(N_NEURONS);

   logic                            in_valid;
   logic                            in_ready;
   logic [N_INPUTS*INPUT_BITS-1:0]  in_vec;
   logic                            w_en;
   logic [AW-1:0]                   w_addr;
   logic [N_INPUTS*WEIGHT_BITS-1:0] w_data;
   logic                            out_valid;
   logic                            out_ready;
   logic [AW-1:0]                   out_idx;
   logic [SUM_BITS-1:0]             out_sum;
   logic                            out_fire;
   logic                            done;

   modport master (
      input  in_valid, in_vec, w_data, out_ready,
      output in_ready, w_en, w_addr, out_valid, out_idx, out_sum, out_fire, done
   );

   modport slave (
      output in_valid, in_vec, w_data, out_ready,
      input  in_ready, w_en, w_addr, out_valid, out_idx, out_sum, out_fire, done
   );

endinterface

// File: rtl/multiplicant.sv
// Lane-wise unsigned multiplier, purely combinational; each product sits zero-extended in an
// INPUT_BITS*WEIGHT_BITS field at the same lane position as its operands.
module multiplicant
   import neuron_sequencer_pkg::*;
#(
   parameter int N_INPUTS    = DEF_N_INPUTS,
   parameter int INPUT_BITS  = DEF_INPUT_BITS,
   parameter int WEIGHT_BITS = DEF_WEIGHT_BITS
) (
   input  logic [N_INPUTS*INPUT_BITS-1:0]             a,
   input  logic [N_INPUTS*WEIGHT_BITS-1:0]            b,
   output logic [N_INPUTS*INPUT_BITS*WEIGHT_BITS-1:0] prod
);
   localparam int PW = INPUT_BITS * WEIGHT_BITS;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_lane
      assign prod[g*PW +: PW] = PW'(a[g*INPUT_BITS +: INPUT_BITS]) * PW'(b[g*WEIGHT_BITS +: WEIGHT_BITS]);
   end

endmodule

// File: rtl/neuron_sequencer.sv
// Evaluates N_NEURONS dot products of one latched vector against ROM weights, 4 cycles per neuron
// (FETCH, MUL, ACC, OUT); results are held in OUT until out_ready, stalling the whole sequence.
module neuron_sequencer
   import neuron_sequencer_pkg::*;
#(
   parameter int N_INPUTS    = DEF_N_INPUTS,
   parameter int INPUT_BITS  = DEF_INPUT_BITS,
   parameter int WEIGHT_BITS = DEF_WEIGHT_BITS,
   parameter int N_NEURONS   = DEF_N_NEURONS,
   parameter int THRESHOLD   = DEF_THRESHOLD
) (
   input logic               clk,
   input logic               rst_n,
   neuron_sequencer_if.master bus
);
   localparam int SUM_BITS = sum_bits(INPUT_BITS, WEIGHT_BITS, N_INPUTS);
   localparam int AW       = $clog2(N_NEURONS);
   localparam int PB       = INPUT_BITS + WEIGHT_BITS;
   localparam int PW       = INPUT_BITS * WEIGHT_BITS;

   state_t                         state, state_nx;
   logic [AW-1:0]                  idx;
   logic [N_INPUTS*INPUT_BITS-1:0] vec_q;
   logic [N_INPUTS*PW-1:0]         prod_all;
   logic [PB-1:0]                  prod_q [N_INPUTS];
   logic [SUM_BITS-1:0]            sum_q, sum_c;
   logic                           fire_q, done_q, last;
   logic [N_INPUTS*(PW-PB)-1:0]    prod_unused;

   assign last = (idx == AW'(N_NEURONS - 1));

   multiplicant #(
      .N_INPUTS   (N_INPUTS),
      .INPUT_BITS (INPUT_BITS),
      .WEIGHT_BITS(WEIGHT_BITS)
   ) u_mult (
      .a   (vec_q),
      .b   (bus.w_data),
      .prod(prod_all)
   );

   // A product never needs more than PB bits; the rest of each field is always zero.
   for (genvar g = 0; g < N_INPUTS; g++) begin : g_hi
      assign prod_unused[g*(PW-PB) +: (PW-PB)] = prod_all[g*PW+PB +: (PW-PB)];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = FETCH;
         FETCH:   state_nx = MUL;
         MUL:     state_nx = ACC;
         ACC:     state_nx = OUT;
         OUT:     if (bus.out_ready) state_nx = last ? IDLE : FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.w_en      = (state == FETCH);
      bus.out_valid = (state == OUT);
      bus.w_addr    = idx;
      bus.out_idx   = idx;
      bus.out_sum   = sum_q;
      bus.out_fire  = fire_q;
      bus.done      = done_q;
   end

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < N_INPUTS; i++) sum_c = sum_c + SUM_BITS'(prod_q[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx    <= '0;
         vec_q  <= '0;
         sum_q  <= '0;
         fire_q <= 1'b0;
         done_q <= 1'b0;
         for (int i = 0; i < N_INPUTS; i++) prod_q[i] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (bus.in_valid) begin
               vec_q <= bus.in_vec;
               idx   <= '0;
            end
            MUL: for (int i = 0; i < N_INPUTS; i++) prod_q[i] <= prod_all[i*PW +: PB];
            ACC: begin
               sum_q  <= sum_c;
               fire_q <= (sum_c >= SUM_BITS'(THRESHOLD));
            end
            OUT: if (bus.out_ready) begin
               if (last) done_q <= 1'b1;
               else      idx    <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a one-cycle-latency weight ROM model.
module tb_neuron_sequencer;
   import neuron_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neuron_sequencer_if bus ();

   neuron_sequencer dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [11:0] rom [8];
   always @(posedge clk) if (bus.w_en) bus.w_data <= rom[bus.w_addr];

   int checks = 0;
   int errors = 0;

   logic [7:0] obs_sum  [8];
   logic       obs_fire [8];
   logic [2:0] obs_idx  [8];
   int         obs_cyc  [8];
   int         obs_n, done_cnt, done_cyc;

   task automatic set_rom(input logic [11:0] val);
      for (int k = 0; k < 8; k++) rom[k] = val;
   endtask

   task automatic start_vec(input logic [11:0] vec);
      int guard;
      guard = 0;
      bus.in_vec   = vec;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Records every accepted result and done pulse, with cycle numbers relative to the handshake.
   task automatic run_vector(input logic [11:0] vec);
      obs_n = 0; done_cnt = 0; done_cyc = -1;
      bus.out_ready = 1'b1;
      start_vec(vec);
      for (int c = 1; c <= 36; c++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1 && obs_n < 8) begin
            obs_sum[obs_n] = bus.out_sum; obs_fire[obs_n] = bus.out_fire;
            obs_idx[obs_n] = bus.out_idx; obs_cyc[obs_n] = c;
            obs_n++;
         end
         if (bus.done === 1'b1) begin done_cnt++; done_cyc = c; end
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_vec = '0; bus.out_ready = 1'b1; bus.w_data = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      checks++; if (bus.w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b want 0", bus.w_en); end
      checks++; if (bus.w_addr !== 3'd0) begin errors++; $display("FAIL reset_w_addr: got %0d want 0", bus.w_addr); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
      checks++; if (bus.out_sum !== 8'd0) begin errors++; $display("FAIL reset_out_sum: got %0d want 0", bus.out_sum); end
      checks++; if (bus.out_fire !== 1'b0) begin errors++; $display("FAIL reset_out_fire: got %b want 0", bus.out_fire); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      set_rom(12'h492);
      run_vector(12'h6DB);
      checks++; if (obs_n !== 8) begin errors++; $display("FAIL basic_count: got %0d results want 8", obs_n); end
      for (int k = 0; k < obs_n; k++) begin
         checks++;
         if (obs_cyc[k] !== 4*(k+1) || obs_idx[k] !== 3'(k) || obs_sum[k] !== 8'd24 || obs_fire[k] !== 1'b1) begin
            errors++;
            $display("FAIL basic_result%0d: got cyc=%0d idx=%0d sum=%0d fire=%b want cyc=%0d idx=%0d sum=24 fire=1",
                     k, obs_cyc[k], obs_idx[k], obs_sum[k], obs_fire[k], 4*(k+1), k);
         end
      end
      checks++; if (done_cnt !== 1 || done_cyc !== 33) begin errors++; $display("FAIL basic_done: got %0d pulses at cycle %0d want 1 at 33", done_cnt, done_cyc); end
   endtask

   task automatic test_zero_max();
      int exp_sum [8];
      logic exp_fire [8];
      exp_sum  = '{0, 56, 56, 56, 56, 56, 56, 196};
      exp_fire = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      set_rom(12'h492); rom[0] = 12'h000; rom[7] = 12'hFFF;
      run_vector(12'hFFF);
      checks++; if (obs_n !== 8) begin errors++; $display("FAIL zeromax_count: got %0d results want 8", obs_n); end
      for (int k = 0; k < obs_n; k++) begin
         checks++;
         if (obs_sum[k] !== 8'(exp_sum[k]) || obs_fire[k] !== exp_fire[k]) begin
            errors++;
            $display("FAIL zeromax_idx%0d: got sum=%0d fire=%b want sum=%0d fire=%b", k, obs_sum[k], obs_fire[k], exp_sum[k], exp_fire[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int phase, hold;
      phase = 0; hold = 0; done_cnt = 0;
      set_rom(12'h492);
      bus.out_ready = 1'b1;
      start_vec(12'h6DB);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (bus.done === 1'b1) done_cnt++;
         if (c == 1) begin
            checks++; if (bus.w_en !== 1'b1 || bus.w_addr !== 3'd0) begin errors++; $display("FAIL bp_first_fetch: got w_en=%b addr=%0d want 1/0", bus.w_en, bus.w_addr); end
         end
         if (phase == 0 && bus.out_valid === 1'b1 && bus.out_idx === 3'd2) begin
            bus.out_ready = 1'b0; phase = 1;
         end else if (phase == 1) begin
            hold++;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd2 || bus.out_sum !== 8'd24 || bus.w_en !== 1'b0) begin
               errors++;
               $display("FAIL bp_hold%0d: got valid=%b idx=%0d sum=%0d w_en=%b want 1/2/24/0", hold, bus.out_valid, bus.out_idx, bus.out_sum, bus.w_en);
            end
            if (hold == 5) begin bus.out_ready = 1'b1; phase = 2; end
         end else if (phase == 2) begin
            checks++; if (bus.w_en !== 1'b1 || bus.w_addr !== 3'd3) begin errors++; $display("FAIL bp_fetch3: got w_en=%b addr=%0d want 1/3", bus.w_en, bus.w_addr); end
            phase = 3;
         end
      end
      checks++; if (phase !== 3) begin errors++; $display("FAIL bp_progress: got phase %0d want 3", phase); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
   endtask

   task automatic test_busy_input();
      bit busy_bad;
      busy_bad = 1'b0; obs_n = 0; done_cnt = 0;
      set_rom(12'h492);
      bus.out_ready = 1'b1;
      start_vec(12'h6DB);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL busy_in_ready_mul: got %b want 0", bus.in_ready); end
            bus.in_valid = 1'b1; bus.in_vec = 12'hFFF;
         end
         if (c > 2 && c <= 32 && bus.in_ready !== 1'b0) busy_bad = 1'b1;
         if (c == 32) bus.in_valid = 1'b0;
         if (bus.out_valid === 1'b1 && obs_n < 8) begin obs_sum[obs_n] = bus.out_sum; obs_n++; end
         if (bus.done === 1'b1) done_cnt++;
      end
      checks++; if (busy_bad !== 1'b0) begin errors++; $display("FAIL busy_in_ready: got in_ready high while busy want low"); end
      checks++; if (obs_n !== 8 || done_cnt !== 1) begin errors++; $display("FAIL busy_count: got %0d results %0d done want 8 and 1", obs_n, done_cnt); end
      for (int k = 0; k < obs_n; k++) begin
         checks++; if (obs_sum[k] !== 8'd24) begin errors++; $display("FAIL busy_sum%0d: got %0d want 24", k, obs_sum[k]); end
      end
      bus.in_vec = '0;
   endtask

   task automatic test_reset_mid();
      bit late_bad;
      late_bad = 1'b0;
      set_rom(12'h492);
      bus.out_ready = 1'b1;
      start_vec(12'h6DB);
      for (int c = 1; c <= 23; c++) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 || bus.w_en !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_state: got in_ready=%b out_valid=%b done=%b w_en=%b want 1/0/0/0", bus.in_ready, bus.out_valid, bus.done, bus.w_en);
      end
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.done !== 1'b0) late_bad = 1'b1;
      end
      checks++; if (late_bad !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got activity after reset want none"); end
      run_vector(12'h6DB);
      checks++;
      if (obs_n !== 8 || obs_idx[0] !== 3'd0 || obs_cyc[0] !== 4 || obs_sum[0] !== 8'd24 || done_cnt !== 1) begin
         errors++;
         $display("FAIL rstmid_restart: got n=%0d idx0=%0d cyc0=%0d sum0=%0d done=%0d want 8/0/4/24/1", obs_n, obs_idx[0], obs_cyc[0], obs_sum[0], done_cnt);
      end
   endtask

   task automatic test_threshold();
      set_rom(12'h492);
      run_vector(12'h492);
      checks++; if (obs_sum[0] !== 8'd16 || obs_fire[0] !== 1'b1) begin errors++; $display("FAIL thr_16: got sum=%0d fire=%b want 16/1", obs_sum[0], obs_fire[0]); end
      rom[0] = 12'h923; rom[1] = 12'h924;
      run_vector(12'h249);
      checks++; if (obs_sum[0] !== 8'd15 || obs_fire[0] !== 1'b0) begin errors++; $display("FAIL thr_15: got sum=%0d fire=%b want 15/0", obs_sum[0], obs_fire[0]); end
      checks++; if (obs_sum[1] !== 8'd16 || obs_fire[1] !== 1'b1) begin errors++; $display("FAIL thr_16b: got sum=%0d fire=%b want 16/1", obs_sum[1], obs_fire[1]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_max();
      test_backpressure();
      test_busy_input();
      test_reset_mid();
      test_threshold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
